// File: rtl/sonar_pkg.sv
// Shared types and defaults for the ultrasonic ranger: FSM state encoding,
// the timeout result code and default timing constants.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4,
    HOLDOFF   = 3'd5
  } sonar_state_e;

  localparam logic [15:0] TIMEOUT_CODE = 16'hFFFF;

  localparam int DEF_CLKS_PER_US  = 50;
  localparam int DEF_TRIG_US      = 10;
  localparam int DEF_US_PER_CM    = 58;
  localparam int DEF_ECHO_WAIT_US = 30000;
  localparam int DEF_MAX_CM       = 400;
  localparam int DEF_PERIOD_US    = 60000;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous echo input into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sonar_ranger.sv
// Ultrasonic range finder: fires a trigger pulse, times the echo and reports
// whole centimetres (or a timeout code) with a one-cycle capture strobe.
module sonar_ranger
  import sonar_pkg::*;
#(
  parameter int CLKS_PER_US  = DEF_CLKS_PER_US,
  parameter int TRIG_US      = DEF_TRIG_US,
  parameter int US_PER_CM    = DEF_US_PER_CM,
  parameter int ECHO_WAIT_US = DEF_ECHO_WAIT_US,
  parameter int MAX_CM       = DEF_MAX_CM,
  parameter int PERIOD_US    = DEF_PERIOD_US
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] Dis,
  output logic        opt,
  output logic        timeout
);

  localparam int TRIG_CYC   = TRIG_US * CLKS_PER_US;
  localparam int WAIT_CYC   = ECHO_WAIT_US * CLKS_PER_US;
  localparam int CM_CYC     = US_PER_CM * CLKS_PER_US;
  localparam int PERIOD_CYC = PERIOD_US * CLKS_PER_US;
  localparam int TMR_MAX    = (TRIG_CYC > WAIT_CYC) ? TRIG_CYC : WAIT_CYC;

  localparam int TMR_W = cnt_width(TMR_MAX);
  localparam int SUB_W = cnt_width(CM_CYC);
  localparam int CM_W  = cnt_width(MAX_CM);
  localparam int PER_W = cnt_width(PERIOD_CYC);

  localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYC - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(WAIT_CYC - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CM_CYC - 1);
  localparam logic [CM_W-1:0]  CM_LAST   = CM_W'(MAX_CM - 1);
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYC - 1);

  sonar_state_e     state;
  sonar_state_e     next_state;
  logic             echo_s;
  logic [TMR_W-1:0] tmr;
  logic [SUB_W-1:0] sub_cnt;
  logic [CM_W-1:0]  cm_cnt;
  logic [PER_W-1:0] per_cnt;
  logic             sub_wrap;
  logic             meas_to;
  logic             state_change;
  logic [15:0]      result_cm;

  sync_2ff u_echo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo),
    .q     (echo_s)
  );

  assign sub_wrap     = (sub_cnt == SUB_LAST);
  assign state_change = (next_state != state);

  // The cycle that moved WAIT_ECHO into MEASURE already saw echo high, so the
  // total high time is one more than the MEASURE count: a pending wrap rounds up.
  assign result_cm = 16'(cm_cnt) + {15'd0, sub_wrap};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    meas_to    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && (per_cnt == '0)) next_state = TRIG;
      end
      TRIG: begin
        if (tmr == TRIG_LAST) next_state = WAIT_ECHO;
      end
      WAIT_ECHO: begin
        if (echo_s) begin
          next_state = MEASURE;
        end else if (tmr == WAIT_LAST) begin
          next_state = DONE;
          meas_to    = 1'b1;
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          next_state = DONE;
        end else if (sub_wrap && (cm_cnt == CM_LAST)) begin
          next_state = DONE;
          meas_to    = 1'b1;
        end
      end
      DONE: begin
        next_state = HOLDOFF;
      end
      HOLDOFF: begin
        if (!echo_s) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    trig = (state == TRIG);
    opt  = (state == DONE);
  end

  // Shared cycle timer for the trigger pulse and the echo-wait window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (state_change) begin
      tmr <= '0;
    end else if ((state == TRIG) || (state == WAIT_ECHO)) begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  // cm_cnt tops out at MAX_CM: the FSM leaves MEASURE on that wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt <= '0;
      cm_cnt  <= '0;
    end else if (state != MEASURE) begin
      sub_cnt <= '0;
      cm_cnt  <= '0;
    end else if (echo_s) begin
      if (sub_wrap) begin
        sub_cnt <= '0;
        cm_cnt  <= cm_cnt + CM_W'(1);
      end else begin
        sub_cnt <= sub_cnt + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
    end else if ((next_state == TRIG) && (state != TRIG)) begin
      per_cnt <= PER_LAST;
    end else if (per_cnt != '0) begin
      per_cnt <= per_cnt - PER_W'(1);
    end
  end

  // Result registers load on entry to DONE so they are valid alongside opt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Dis     <= 16'h0000;
      timeout <= 1'b0;
    end else if ((next_state == DONE) && (state != DONE)) begin
      Dis     <= meas_to ? TIMEOUT_CODE : result_cm;
      timeout <= meas_to;
    end
  end

endmodule

// File: tb/tb_sonar_ranger.sv
// Directed bench for sonar_ranger at 1 clk/us with short echo-wait, range and period limits.
module tb_sonar_ranger;
  import sonar_pkg::*;

  localparam int CLKS_PER_US  = 1;
  localparam int TRIG_US      = 10;
  localparam int US_PER_CM    = 58;
  localparam int ECHO_WAIT_US = 200;
  localparam int MAX_CM       = 30;
  localparam int PERIOD_US    = 2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        echo;
  logic        trig;
  logic        opt;
  logic        timeout;
  logic [15:0] Dis;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  int   cyc       = 0;
  int   rise_cnt  = 0;
  int   fall_cnt  = 0;
  int   opt_cnt   = 0;
  int   last_rise = 0;
  int   last_fall = 0;
  int   last_opt  = 0;
  int   last_len  = 0;
  int   hi_len    = 0;
  int   prev_rise = 0;
  logic trig_q    = 1'b0;

  sonar_ranger #(
    .CLKS_PER_US  (CLKS_PER_US),
    .TRIG_US      (TRIG_US),
    .US_PER_CM    (US_PER_CM),
    .ECHO_WAIT_US (ECHO_WAIT_US),
    .MAX_CM       (MAX_CM),
    .PERIOD_US    (PERIOD_US)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .echo    (echo),
    .trig    (trig),
    .Dis     (Dis),
    .opt     (opt),
    .timeout (timeout)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge monitor: trigger rises/falls/widths and opt strobes, sampled on negedge.
  always @(negedge clk) begin
    if (trig && !trig_q) begin
      rise_cnt  <= rise_cnt + 1;
      last_rise <= cyc;
      hi_len    <= 1;
    end else if (trig) begin
      hi_len <= hi_len + 1;
    end
    if (!trig && trig_q) begin
      fall_cnt  <= fall_cnt + 1;
      last_fall <= cyc;
      last_len  <= hi_len;
    end
    trig_q <= trig;
    if (opt) begin
      opt_cnt  <= opt_cnt + 1;
      last_opt <= cyc;
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // which: 0 = trig rise, 1 = trig fall, 2 = opt strobe
  task automatic wait_count(input int which, input int budget, output bit ok);
    int start;
    start = (which == 0) ? rise_cnt : (which == 1) ? fall_cnt : opt_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (((which == 0) ? rise_cnt : (which == 1) ? fall_cnt : opt_cnt) != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_measure(input bit skip_rise, input int width, input logic [15:0] exp_dis,
                            input logic exp_to, input string nm, output int rise_at);
    int          o0;
    bit          ok;
    logic [15:0] exp;
    o0 = opt_cnt;
    if (!skip_rise) begin
      wait_count(0, 2100, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL %s trig_rise: no trigger within 2100 cycles", nm); end
    end
    rise_at = last_rise;
    wait_count(1, 30, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s trig_fall: trigger did not fall within 30 cycles", nm); end
    n_checks++;
    if (last_len !== 10) begin n_fail++; $display("FAIL %s trig_width: got %0d required 10", nm, last_len); end
    repeat (5) tick();
    if (width > 0) begin
      echo = 1'b1;
      repeat (width) tick();
      echo = 1'b0;
    end
    exp_q.push_back(exp_dis);
    wait_count(2, 400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s opt_seen: no opt within 400 cycles", nm); end
    exp = exp_q.pop_front();
    n_checks++;
    if (Dis !== exp) begin n_fail++; $display("FAIL %s dis: got %0h required %0h", nm, Dis, exp); end
    n_checks++;
    if (timeout !== exp_to) begin n_fail++; $display("FAIL %s timeout: got %0b required %0b", nm, timeout, exp_to); end
    if (width == 0) begin
      n_checks++;
      if (last_opt - last_fall != 200) begin
        n_fail++; $display("FAIL %s wait_len: got %0d required 200", nm, last_opt - last_fall);
      end
    end
    tick();
    n_checks++;
    if (opt !== 1'b0) begin n_fail++; $display("FAIL %s opt_width: got %0b required 0", nm, opt); end
    n_checks++;
    if (Dis !== exp) begin n_fail++; $display("FAIL %s dis_hold: got %0h required %0h", nm, Dis, exp); end
    n_checks++;
    if (opt_cnt - o0 != 1) begin n_fail++; $display("FAIL %s opt_count: got %0d required 1", nm, opt_cnt - o0); end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    echo  = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %0b required 0", trig); end
    n_checks++;
    if (opt !== 1'b0) begin n_fail++; $display("FAIL reset_opt: got %0b required 0", opt); end
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %0b required 0", timeout); end
    n_checks++;
    if (Dis !== 16'h0000) begin n_fail++; $display("FAIL reset_dis: got %0h required 0", Dis); end
    rst_n = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (rise_cnt != 0) begin n_fail++; $display("FAIL idle_no_trig: got %0d rises required 0", rise_cnt); end
  endtask

  task automatic test_basic();
    int c;
    int r0;
    int r;
    en = 1'b1;
    c  = cyc;
    r0 = rise_cnt;
    tick();
    n_checks++;
    if (rise_cnt != r0 + 1 || last_rise != c + 1) begin
      n_fail++; $display("FAIL first_trig: rise at %0d required %0d", last_rise, c + 1);
    end
    do_measure(1'b1, 580, 16'd10, 1'b0, "echo580", r);
    prev_rise = r;
  endtask

  task automatic test_back_to_back();
    int r;
    do_measure(1'b0, 579, 16'd9, 1'b0, "echo579", r);
    n_checks++;
    if (r - prev_rise != 2000) begin n_fail++; $display("FAIL period_1: got %0d required 2000", r - prev_rise); end
    prev_rise = r;
    do_measure(1'b0, 57, 16'd0, 1'b0, "echo57", r);
    n_checks++;
    if (r - prev_rise != 2000) begin n_fail++; $display("FAIL period_2: got %0d required 2000", r - prev_rise); end
    prev_rise = r;
  endtask

  task automatic test_timeout();
    int r;
    do_measure(1'b0, 0, TIMEOUT_CODE, 1'b1, "no_echo", r);
    n_checks++;
    if (r - prev_rise != 2000) begin n_fail++; $display("FAIL period_3: got %0d required 2000", r - prev_rise); end
  endtask

  task automatic test_stuck_echo();
    bit          ok;
    int          t0;
    int          t1;
    int          r0;
    int          ce;
    int          ce2;
    logic [15:0] exp;
    wait_count(0, 2100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stuck_rise: no trigger within 2100 cycles"); end
    t0 = last_rise;
    r0 = rise_cnt;
    wait_count(1, 30, ok);
    repeat (5) tick();
    echo = 1'b1;
    ce   = cyc;
    exp_q.push_back(TIMEOUT_CODE);
    wait_count(2, 2000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stuck_opt: no opt within 2000 cycles"); end
    exp = exp_q.pop_front();
    n_checks++;
    if (Dis !== exp) begin n_fail++; $display("FAIL stuck_dis: got %0h required %0h", Dis, exp); end
    n_checks++;
    if (timeout !== 1'b1) begin n_fail++; $display("FAIL stuck_timeout: got %0b required 1", timeout); end
    // 2 synchronizer cycles + 1 WAIT_ECHO exit + 1740 MEASURE cycles
    n_checks++;
    if (last_opt - ce != 1743) begin n_fail++; $display("FAIL stuck_latency: got %0d required 1743", last_opt - ce); end
    while (cyc < t0 + 2300) tick();
    n_checks++;
    if (rise_cnt != r0) begin n_fail++; $display("FAIL stuck_block: got %0d extra rises required 0", rise_cnt - r0); end
    echo = 1'b0;
    ce2  = cyc;
    wait_count(0, 20, ok);
    n_checks++;
    if (!ok || last_rise != ce2 + 4) begin
      n_fail++; $display("FAIL release_trig: rise at %0d required %0d", last_rise, ce2 + 4);
    end
    t1 = last_rise;
    wait_count(1, 30, ok);
    repeat (5) tick();
    echo = 1'b1;
    exp_q.push_back(TIMEOUT_CODE);
    wait_count(2, 2000, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || Dis !== exp) begin n_fail++; $display("FAIL stuck2_dis: got %0h required %0h", Dis, exp); end
    while (cyc < t1 + 1800) tick();
    echo = 1'b0;
    wait_count(0, 400, ok);
    n_checks++;
    if (!ok || last_rise != t1 + 2000) begin
      n_fail++; $display("FAIL stuck2_period: rise at %0d required %0d", last_rise, t1 + 2000);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int o_snap;
    int r0;
    int c;
    int r;
    wait_count(1, 30, ok);
    repeat (5) tick();
    echo = 1'b1;
    repeat (100) tick();
    o_snap = opt_cnt;
    rst_n  = 1'b0;
    #1;
    n_checks++;
    if (trig !== 1'b0) begin n_fail++; $display("FAIL midrst_trig: got %0b required 0", trig); end
    n_checks++;
    if (opt !== 1'b0) begin n_fail++; $display("FAIL midrst_opt: got %0b required 0", opt); end
    n_checks++;
    if (Dis !== 16'h0000) begin n_fail++; $display("FAIL midrst_dis: got %0h required 0", Dis); end
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL midrst_timeout: got %0b required 0", timeout); end
    echo = 1'b0;
    en   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    r0 = rise_cnt;
    repeat (20) tick();
    n_checks++;
    if (opt_cnt != o_snap) begin n_fail++; $display("FAIL midrst_no_opt: got %0d strobes required 0", opt_cnt - o_snap); end
    n_checks++;
    if (rise_cnt != r0) begin n_fail++; $display("FAIL midrst_no_trig: got %0d rises required 0", rise_cnt - r0); end
    en = 1'b1;
    c  = cyc;
    tick();
    n_checks++;
    if (rise_cnt != r0 + 1 || last_rise != c + 1) begin
      n_fail++; $display("FAIL midrst_first_trig: rise at %0d required %0d", last_rise, c + 1);
    end
    do_measure(1'b1, 116, 16'd2, 1'b0, "post_reset", r);
  endtask

  task automatic test_en_drop();
    bit          ok;
    int          rc;
    logic [15:0] exp;
    wait_count(0, 2100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL endrop_rise: no trigger within 2100 cycles"); end
    wait_count(1, 30, ok);
    en = 1'b0;
    repeat (5) tick();
    echo = 1'b1;
    repeat (232) tick();
    echo = 1'b0;
    exp_q.push_back(16'd4);
    wait_count(2, 400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL endrop_opt: no opt within 400 cycles"); end
    exp = exp_q.pop_front();
    n_checks++;
    if (Dis !== exp || timeout !== 1'b0) begin
      n_fail++; $display("FAIL endrop_dis: got %0h/%0b required %0h/0", Dis, timeout, exp);
    end
    rc = rise_cnt;
    repeat (2500) tick();
    n_checks++;
    if (rise_cnt != rc) begin n_fail++; $display("FAIL endrop_no_trig: got %0d rises required 0", rise_cnt - rc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_stuck_echo();
    test_reset_mid();
    test_en_drop();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d left required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sonar_ranger.md
SONAR_RANGER -- requirements
Module: sonar_ranger

Interface
REQ-001 Parameter CLKS_PER_US, default 50, clk cycles per microsecond.
REQ-002 Parameter TRIG_US, default 10, trigger pulse width in microseconds.
REQ-003 Parameter US_PER_CM, default 58, echo microseconds per centimetre of range.
REQ-004 Parameter ECHO_WAIT_US, default 30000, maximum wait from trigger end to echo rise.
REQ-005 Parameter MAX_CM, default 400, maximum reportable range in centimetres.
REQ-006 Parameter PERIOD_US, default 60000, minimum interval between trigger starts.
REQ-007 clk  input  1  single system clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  reset; asynchronous, active-low.
REQ-009 en  input  1  when high, measurements repeat every PERIOD_US.
REQ-010 echo  input  1  sensor echo; asynchronous to clk.
REQ-011 trig  output  1  sensor trigger pulse.
REQ-012 Dis  output  16  last measured range in cm, or 16'hFFFF on timeout; feeds the downstream capture register.
REQ-013 opt  output  1  one-cycle strobe marking a new Dis value; drives the downstream capture enable.
REQ-014 timeout  output  1  high when the current Dis value is a timeout result.

Function
REQ-015 echo SHALL pass through a 2-flop synchronizer; all echo references below mean the synchronized signal.
REQ-016 FSM states SHALL be IDLE, TRIG, WAIT_ECHO, MEASURE, DONE, HOLDOFF.
REQ-017 IDLE->TRIG when en=1 and the period counter is 0; the period counter SHALL load PERIOD_US*CLKS_PER_US-1 on entry to TRIG and decrement to 0 each cycle.
REQ-018 In TRIG, trig SHALL be 1 for exactly TRIG_US*CLKS_PER_US cycles, then WAIT_ECHO; trig SHALL be 0 in all other states.
REQ-019 In WAIT_ECHO, echo=1 SHALL go to MEASURE; if ECHO_WAIT_US*CLKS_PER_US cycles elapse first, the result SHALL be a timeout and the FSM SHALL go to DONE.
REQ-020 In MEASURE, a sub-counter SHALL count 0..US_PER_CM*CLKS_PER_US-1 and increment a cm counter on each wrap, starting from 0,0 on entry.
REQ-021 Result = floor(echo high cycles / (US_PER_CM*CLKS_PER_US)); echo=0 in MEASURE SHALL go to DONE with this value.
REQ-022 If the cm counter reaches MAX_CM while echo is still 1, the result SHALL be a timeout and the FSM SHALL go to DONE.
REQ-023 In DONE (one cycle), Dis SHALL load the result (16'hFFFF on timeout), timeout SHALL load 1 on timeout and 0 otherwise, and opt SHALL be 1; opt SHALL be 0 in every other cycle.
REQ-024 Dis and timeout SHALL hold between opt strobes.
REQ-025 HOLDOFF->IDLE only when echo=0; a stuck-high echo SHALL block all further triggers.
REQ-026 en deasserted mid-measurement SHALL NOT abort; the measurement completes with its opt, and no new TRIG starts until en=1.
REQ-027 Counter widths SHALL be sized from parameters; the cm counter SHALL NOT wrap; MAX_CM SHALL be < 16'hFFFF.

Reset
REQ-028 rst_n=0 SHALL immediately force trig=0, opt=0, timeout=0, Dis=16'h0000, state IDLE, all counters 0, synchronizer flops 0.
REQ-029 Reset mid-measurement SHALL discard the measurement with no opt strobe; after release, the first trigger starts on the first cycle in which en=1.

Structure
REQ-030 Package sonar_pkg SHALL hold the state enum, TIMEOUT_CODE=16'hFFFF, and the default parameter constants.
REQ-031 Sub-module sync_2ff SHALL implement the echo synchronizer.

Verification (CLKS_PER_US=1, MAX_CM=30, ECHO_WAIT_US=200, PERIOD_US=2000)
REQ-032 Reset, en=1, echo high 580 cycles after trig -> trig high 10 cycles; one opt; Dis=10; timeout=0.
REQ-033 Echo high 579 cycles -> Dis=9 (floor); echo high 57 cycles -> Dis=0.
REQ-034 No echo -> opt 200 cycles after trig falls; Dis=16'hFFFF; timeout=1.
REQ-035 Echo held high -> timeout opt after 1740 cycles in MEASURE; no further trig until echo=0, then next trig at the 2000-cycle period.
REQ-036 rst_n pulsed low mid-MEASURE -> outputs 0 immediately; no opt; new trig on the first en=1 cycle after release.
REQ-037 en dropped during WAIT_ECHO -> measurement completes with opt; no further trig while en=0.
